// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle unsigned multiply / restoring divide sequencer.
// Produces a WIDTH x WIDTH product or a WIDTH / WIDTH quotient and remainder
// in hi/lo. It has no adder of its own. Every iteration borrows the shared
// ripple ALU through the alu_* control/operand ports, one ALU pass per bit.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_ainvert,
  output logic             alu_bnegate,
  output logic             alu_cin,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [1:0] ALU_ADD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op_div;
  logic [WIDTH-1:0] operand;

  // Restoring-divide view of the partial remainder: hi:lo shifted left by one,
  // split into the bit that falls off the top and the WIDTH-bit remainder.
  logic             div_msb;
  logic [WIDTH-1:0] div_rem;
  logic             div_ok;

  assign div_msb = hi[WIDTH-1];
  assign div_rem = {hi[WIDTH-2:0], lo[WIDTH-1]};
  // With msb set the true remainder is at least 2^WIDTH, so it always
  // covers the divisor even when the ALU reports no carry.
  assign div_ok  = alu_cout | div_msb;

  assign busy = (state == CALC);
  assign done = (state == DONE);

  // Drive the shared ALU only while iterating; outside CALC it sees all zeros.
  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_ainvert = 1'b0;
    alu_bnegate = 1'b0;
    alu_cin     = 1'b0;
    alu_op      = 2'd0;
    if (state == CALC) begin
      alu_op = ALU_ADD;
      if (op_div) begin
        alu_a       = div_rem;
        alu_b       = operand;
        alu_bnegate = 1'b1;
        alu_cin     = 1'b1;
      end else begin
        alu_a = hi;
        alu_b = lo[0] ? operand : '0;
      end
    end
  end

  // Sequencer: accepts a start in IDLE or DONE, runs WIDTH iterations in CALC,
  // then shows DONE for one cycle. Divide by zero skips straight to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_div      <= 1'b0;
      operand     <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cnt         <= '0;
            op_div      <= is_div;
            div_by_zero <= 1'b0;
            if (is_div && (src_b == '0)) begin
              operand     <= src_b;
              hi          <= src_a;
              lo          <= '1;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else if (is_div) begin
              operand <= src_b;
              hi      <= '0;
              lo      <= src_a;
              state   <= CALC;
            end else begin
              operand <= src_a;
              hi      <= '0;
              lo      <= src_b;
              state   <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (op_div) begin
            hi <= div_ok ? alu_result : div_rem;
            lo <= {lo[WIDTH-2:0], div_ok};
          end else begin
            {hi, lo} <= {alu_cout, alu_result, lo[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq, with a
// behavioural model of the shared ripple ALU hooked to the alu_* ports.
module tb_muldiv_seq;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic         is_div;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         alu_ainvert;
  logic         alu_bnegate;
  logic         alu_cin;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_result;
  logic         alu_cout;

  int compared;
  int mismatched;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_div      (is_div),
    .src_a       (src_a),
    .src_b       (src_b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ainvert (alu_ainvert),
    .alu_bnegate (alu_bnegate),
    .alu_cin     (alu_cin),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_cout    (alu_cout)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the shared ripple ALU chain.
  always_comb begin
    logic [W-1:0] a_eff;
    logic [W-1:0] b_eff;
    logic [W:0]   sum;
    a_eff      = alu_ainvert ? ~alu_a : alu_a;
    b_eff      = alu_bnegate ? ~alu_b : alu_b;
    sum        = {1'b0, a_eff} + {1'b0, b_eff} + {{W{1'b0}}, alu_cin};
    alu_cout   = sum[W];
    alu_result = '0;
    case (alu_op)
      2'd0:    alu_result = a_eff & b_eff;
      2'd1:    alu_result = a_eff | b_eff;
      2'd2:    alu_result = sum[W-1:0];
      default: alu_result = {{(W-1){1'b0}}, sum[W-1]};
    endcase
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one start pulse; returns 1 ns after the sampling edge (cycle 1).
  task automatic applyStimulus(input logic div, input logic [W-1:0] a, input logic [W-1:0] b);
    start  = 1'b1;
    is_div = div;
    src_a  = a;
    src_b  = b;
    tick();
    start  = 1'b0;
    src_a  = '0;
    src_b  = '0;
    is_div = 1'b0;
  endtask

  // Waits for done, counting cycles since the start edge and busy cycles seen.
  task automatic waitDone(input int first_cycle, output int cycle, output int busy_cnt);
    cycle    = first_cycle;
    busy_cnt = 0;
    while (!done && cycle < 200) begin
      if (busy) busy_cnt++;
      tick();
      cycle++;
    end
    if (!done) checkOutput("done_timeout", 64'(cycle), 64'd0);
  endtask

  // Full operation with result and timing checks.
  task automatic runOp(input string tag, input logic div, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                       input logic [W-1:0] exp_lo, input logic exp_dbz,
                       input int exp_cycle, input int exp_busy);
    int cycle;
    int busy_cnt;
    applyStimulus(div, a, b);
    waitDone(1, cycle, busy_cnt);
    checkOutput({tag, "_cycle"}, 64'(cycle), 64'(exp_cycle));
    checkOutput({tag, "_busycnt"}, 64'(busy_cnt), 64'(exp_busy));
    checkOutput({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    checkOutput({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    checkOutput({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
  endtask

  initial begin
    int cycle;
    int busy_cnt;
    int done_seen;
    compared   = 0;
    mismatched = 0;
    rst    = 1'b1;
    start  = 1'b0;
    is_div = 1'b0;
    src_a  = '0;
    src_b  = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] reset state");
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_hi", 64'(hi), 64'd0);
    checkOutput("rst_lo", 64'(lo), 64'd0);
    checkOutput("rst_dbz", 64'(div_by_zero), 64'd0);
    checkOutput("rst_alu", {alu_a, alu_b[29:0], alu_op, alu_ainvert, alu_bnegate}, 64'd0);

    $display("[TB] small multiply");
    runOp("mul7x6", 1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 33, 32);
    tick();
    checkOutput("mul7x6_done_drop", 64'(done), 64'd0);
    checkOutput("mul7x6_hold", {hi, lo}, {32'd0, 32'd42});
    checkOutput("idle_alu_a", 64'(alu_a), 64'd0);

    $display("[TB] carry-out multiply");
    runOp("mulmax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 32);

    $display("[TB] divides");
    runOp("div100_7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 32);
    runOp("divmax_1", 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 33, 32);
    runOp("divmsb", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33, 32);
    tick();

    $display("[TB] divide by zero");
    runOp("div5_0", 1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1, 0);
    tick();
    runOp("mul9x3", 1'b0, 32'd9, 32'd3, 32'd0, 32'd27, 1'b0, 33, 32);

    $display("[TB] start while busy, then start on the done cycle");
    applyStimulus(1'b0, 32'd7, 32'd6);
    for (int i = 1; i < 10; i++) tick();
    start  = 1'b1;
    is_div = 1'b1;
    src_a  = 32'd1000;
    src_b  = 32'd3;
    tick();
    start  = 1'b0;
    is_div = 1'b0;
    src_a  = '0;
    src_b  = '0;
    waitDone(11, cycle, busy_cnt);
    checkOutput("ignore_cycle", 64'(cycle), 64'd33);
    checkOutput("ignore_result", {hi, lo}, {32'd0, 32'd42});
    applyStimulus(1'b0, 32'd3, 32'd5);
    checkOutput("b2b_busy", 64'(busy), 64'd1);
    waitDone(1, cycle, busy_cnt);
    checkOutput("b2b_cycle", 64'(cycle), 64'd33);
    checkOutput("b2b_lo", 64'(lo), 64'd15);
    tick();

    $display("[TB] reset mid-divide");
    applyStimulus(1'b1, 32'd100, 32'd7);
    for (int i = 1; i < 15; i++) tick();
    checkOutput("mid_busy_before", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_state", {busy, done, div_by_zero}, 64'd0);
    checkOutput("mid_rst_hilo", {hi, lo}, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) done_seen++;
      tick();
    end
    checkOutput("mid_rst_no_done", 64'(done_seen), 64'd0);
    runOp("post_rst_div", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle unsigned multiply/divide sequencer for the CPU datapath. It computes a WIDTH×WIDTH product or a WIDTH÷WIDTH quotient/remainder into HI/LO registers. It adds no adder of its own: every iteration borrows the shared ripple ALU (the chain of 1-bit ALU slices) through an explicit control/operand interface. Shift-add multiply and restoring divide take one ALU pass per bit.

## Interface
- WIDTH, 32, operand/HI/LO width; ALU chain width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin operation; accepted only when busy=0.
- is_div  in  1  1 = divide, 0 = multiply; sampled with start.
- src_a  in  WIDTH  multiplicand / dividend; sampled with start.
- src_b  in  WIDTH  multiplier / divisor; sampled with start.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse; hi/lo/div_by_zero valid from this cycle.
- hi  out  WIDTH  product upper half / remainder.
- lo  out  WIDTH  product lower half / quotient.
- div_by_zero  out  1  set by a divide with src_b=0; cleared by the next accepted start.
- alu_a, alu_b  out  WIDTH  ALU operands.
- alu_ainvert, alu_bnegate, alu_cin  out  1  ALU slice controls (cin drives slice 0).
- alu_op  out  2  ALU op: 0 AND, 1 OR, 2 ADD, 3 SLT.
- alu_result  in  WIDTH  ALU sum.
- alu_cout  in  1  carry out of the MSB slice.

## Operation
- States: IDLE, CALC, DONE. Iteration counter cnt is clog2(WIDTH)+1 bits.
- IDLE/DONE + start:
  - Latch operands; clear div_by_zero; cnt←0.
  - If is_div and src_b=0: hi←src_a, lo←all ones, div_by_zero←1, go to DONE.
  - Else go to CALC. Multiply loads hi←0, lo←src_b, mcand←src_a. Divide loads hi←0, lo←src_a, dvsr←src_b.
- DONE without start → IDLE. IDLE without start → stay.
- CALC multiply iteration:
  - ALU gets alu_a=hi, alu_b=(lo[0] ? mcand : 0), alu_op=2, ainvert=0, bnegate=0, cin=0.
  - Update {hi,lo} ← {alu_cout, alu_result, lo[WIDTH-1:1]}, a (2·WIDTH+1)-bit value right-shifted by one.
- CALC divide iteration (restoring):
  - Form {msb, r} = {hi, lo[WIDTH-1]}, WIDTH+1 bits.
  - ALU gets alu_a=r, alu_b=dvsr, alu_op=2, bnegate=1, cin=1.
  - ok = alu_cout | msb.
  - hi ← ok ? alu_result : r; lo ← {lo[WIDTH-2:0], ok}.
- After the WIDTH-th iteration (cnt=WIDTH-1 at the edge), go to DONE.
- Outside CALC: alu_a=0, alu_b=0, alu_op=0, all ALU controls 0.
- start while busy=1 is ignored. Operands and is_div are not resampled.
- hi/lo hold their final values through IDLE until the next accepted start.

## Timing
- Reset (async, immediate): state IDLE, busy 0, done 0, hi 0, lo 0, div_by_zero 0, cnt 0. ALU outputs at IDLE values.
- Reset mid-CALC aborts the operation. No done pulse. All outputs take reset values.
- busy = (state==CALC). It rises the cycle after the start edge and stays high exactly WIDTH cycles.
- done = (state==DONE). On a normal operation, done is high in the cycle WIDTH+1 cycles after the edge that sampled start.
- Divide by zero: done is high the cycle immediately after the start edge; busy never rises.
- Back-to-back: start in the DONE cycle is accepted. Next busy rises on the following cycle, with no idle gap.
- The ALU path is combinational within one cycle: outputs → alu_result/alu_cout → register inputs. No ALU latency is budgeted.
- The ALU may be used by others only while busy=0.

## Test plan
- Small multiply: WIDTH=32, mult 7×6 → busy high cycles 1..32, done at cycle 33, hi=0, lo=42; next cycle done=0, hi/lo held.
- Carry-out multiply: 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. This exercises alu_cout shift-in.
- Divides:
  - 100÷7 → lo=14, hi=2, div_by_zero=0.
  - 0xFFFFFFFF÷1 → lo=0xFFFFFFFF, hi=0.
  - 0x80000000÷0xFFFFFFFF → lo=0, hi=0x80000000. This exercises the msb path.
- Divide by zero: 5÷0 → done the cycle after start, busy never high, hi=5, lo=0xFFFFFFFF, div_by_zero=1. A following 9×3 clears the flag; result lo=27.
- Start while busy: pulse start with new operands at cycle 10 of a running multiply → ignored, original result returned. Start on the DONE cycle → accepted; busy rises the next cycle.
- Reset mid-op: assert rst asynchronously at cycle 15 of a divide → busy/done/hi/lo/div_by_zero go to 0 immediately, no done pulse. A fresh start after release completes correctly.
